fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  - Sequencing controller for the synchronous FIFO: owns the read and write pointers and the occupancy count.
//  - Generates memory write/read strobes and addresses, and full/empty/almost flags.
//  - Sits between producer/consumer handshakes and the dual-port storage array.
//  - Replaces the combinational pointer comparison with registered, next-state-derived flags.
// PARAMETERS
//  SIZE      4   address width; DEPTH = 2**SIZE entries (16)
//  AF_LEVEL  14  almost_full asserted when count >= AF_LEVEL (0..DEPTH)
//  AE_LEVEL  2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH)
// PORTS
//  clk           in   1       rising-edge clock, sole clock
//  rst           in   1       synchronous reset, active-high
//  wr_en         in   1       producer write request
//  rd_en         in   1       consumer read request
//  flush         in   1       sync clear of pointers/count; does not clear error flags
//  clr_err       in   1       clears overflow/underflow
//  mem_we        out  1       storage write strobe (combinational = write accepted)
//  mem_waddr     out  SIZE    storage write address = wptr[SIZE-1:0]
//  mem_re        out  1       storage read strobe (combinational = read accepted)
//  mem_raddr     out  SIZE    storage read address = rptr[SIZE-1:0]
//  rd_valid      out  1       registered; storage data valid (1 cycle after mem_re)
//  full          out  1       registered full flag
//  empty         out  1       registered empty flag
//  almost_full   out  1       registered, count >= AF_LEVEL
//  almost_empty  out  1       registered, count <= AE_LEVEL
//  count         out  SIZE+1  registered occupancy, 0..DEPTH
//  overflow      out  1       sticky: write requested while full
//  underflow     out  1       sticky: read requested while empty
// BEHAVIOUR
//  - Pointers wptr/rptr are SIZE+1 bits; the MSB is the wrap bit.
//    - empty: wptr == rptr.
//    - full: address bits equal, wrap bits differ.
//  - Reset: pointers=0, count=0, empty=1, full=0, almost_empty=1 (AE_LEVEL >= 0), almost_full=0,
//    rd_valid=0, overflow=0, underflow=0.
//  - Reset asserted mid-operation: all of the above take effect at the next edge; in-flight rd_valid is dropped.
//  - Write accepted: wr_ok = wr_en & ~full & ~flush.
//    - mem_we = wr_ok, same cycle; wptr increments at the edge.
//  - Read accepted: rd_ok = rd_en & ~empty & ~flush.
//    - mem_re = rd_ok, same cycle; rptr increments at the edge.
//    - rd_valid = 1 in the following cycle (storage has 1-cycle read latency).
//  - Acceptance uses current registered flags only; there is no fall-through.
//    - Empty + rd_en + wr_en: write accepted, read rejected, underflow set.
//    - Full + rd_en + wr_en: read accepted, write rejected, overflow set.
//    - Not full/not empty + both: both accepted, count unchanged.
//  - count_next = count + wr_ok - rd_ok.
//  - Flags are computed from pointer/count next-state and registered, so they are valid in the cycle after the edge.
//  - Wrap: pointers roll 2*DEPTH-1 -> 0 naturally; address wraps DEPTH-1 -> 0.
//  - flush (rst=0): pointers=0, count=0, empty=1, full=0, rd_valid=0 at next edge; mem_we/mem_re forced 0 that cycle.
//  - overflow set on wr_en & full; underflow set on rd_en & empty.
//    - Sticky until clr_err or rst; a set event in the same cycle as clr_err wins (flag stays 1).
//  - rst has priority over flush, flush over normal operation.
// STRUCTURE
//  - Package fifo_pkg: localparam DEPTH, pointer/count typedefs ptr_t (SIZE+1 bits) and cnt_t (SIZE+1 bits),
//    and the function ptr_full(wptr, rptr).
//  - Sub-module fifo_ptr: one SIZE+1-bit pointer register with inc/clr inputs, instantiated twice (wptr, rptr).
//  - Flag logic and error logic stay in fifo_ctrl.
// TESTING
//  - Reset then idle 5 cycles -> empty=1, almost_empty=1, full=0, count=0, all strobes 0.
//  - 16 writes, no reads -> count=16, full=1 after the 16th edge, almost_full=1 from count=14, mem_waddr 0..15.
//  - 17th write while full -> mem_we=0, overflow=1 and stays 1 until clr_err; count stays 16.
//  - Fill to 16, then rd_en+wr_en together for 3 cycles -> only reads accepted, count 15,
//    then rd_valid each cycle after the first read; subsequent both-cycles hold count.
//  - Drain a full FIFO -> empty=1 after the 16th read; next rd_en -> mem_re=0, underflow=1.
//    Then 40 interleaved write/read pairs -> addresses wrap 15->0, wrap bit toggles, no false full/empty.
//  - Assert flush with count=7 and rd_en=1 -> mem_re=0, next cycle count=0, empty=1, rd_valid=0,
//    overflow/underflow unchanged; rst during the 10th write -> all reset values next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared sizing, types and helpers for the synchronous FIFO controller.
//   SIZE    : address width of the storage array
//   DEPTH   : number of storage entries (2**SIZE)
//   ptr_t   : read/write pointer, SIZE address bits plus one wrap bit
//   cnt_t   : occupancy count, 0..DEPTH
//   addr_t  : storage address
//   ptr_full/ptr_empty : occupancy decode from a pair of pointers
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int SIZE  = 4;
    localparam int DEPTH = 2 ** SIZE;

    typedef logic [SIZE:0]   ptr_t;
    typedef logic [SIZE:0]   cnt_t;
    typedef logic [SIZE-1:0] addr_t;

    // Same slot, different lap: the writer is exactly one lap ahead.
    function automatic logic ptr_full(input ptr_t wptr, input ptr_t rptr);
        return (wptr[SIZE-1:0] == rptr[SIZE-1:0]) && (wptr[SIZE] != rptr[SIZE]);
    endfunction

    // Same slot on the same lap: nothing is waiting to be read.
    function automatic logic ptr_empty(input ptr_t wptr, input ptr_t rptr);
        return wptr == rptr;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_if
// Handshake and storage-side bundle of the FIFO controller.
//   master : producer/consumer side, drives wr_en, rd_en, flush, clr_err and
//            observes strobes, addresses, flags and count
//   slave  : the controller itself
// Signals:
//   wr_en, rd_en, flush, clr_err          requests into the controller
//   mem_we, mem_waddr, mem_re, mem_raddr  storage strobes and addresses
//   rd_valid                              storage read data valid
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                   sticky error flags
// ---------------------------------------------------------------------------
interface fifo_ctrl_if;
    import fifo_pkg::*;

    logic  wr_en;
    logic  rd_en;
    logic  flush;
    logic  clr_err;
    logic  mem_we;
    addr_t mem_waddr;
    logic  mem_re;
    addr_t mem_raddr;
    logic  rd_valid;
    logic  full;
    logic  empty;
    logic  almost_full;
    logic  almost_empty;
    cnt_t  count;
    logic  overflow;
    logic  underflow;

    modport master (
        output wr_en, rd_en, flush, clr_err,
        input  mem_we, mem_waddr, mem_re, mem_raddr, rd_valid,
        input  full, empty, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, flush, clr_err,
        output mem_we, mem_waddr, mem_re, mem_raddr, rd_valid,
        output full, empty, almost_full, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
// One FIFO pointer register (address bits plus wrap bit).
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, pointer -> 0
//   i_inc      : advance the pointer by one at the next edge
//   i_clr      : clear the pointer at the next edge (overrides i_inc)
//   o_ptr      : current registered pointer
//   o_ptrNext  : value the pointer takes at the next edge (ignoring rst),
//                exported so the owner can register flags from it
// ---------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output ptr_t o_ptr,
    output ptr_t o_ptrNext
);

    ptr_t r_ptr;
    ptr_t w_ptrNext;

    // Next pointer value; the wrap bit rolls over naturally at 2*DEPTH-1.
    always_comb begin
        w_ptrNext = r_ptr;
        if (i_clr) begin
            w_ptrNext = '0;
        end else if (i_inc) begin
            w_ptrNext = r_ptr + ptr_t'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptrNext;
        end
    end

    assign o_ptr     = r_ptr;
    assign o_ptrNext = w_ptrNext;

endmodule

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
// Sequencing controller for a synchronous FIFO with a dual-port storage
// array holding DEPTH entries and a one-cycle read latency. Owns the read
// and write pointers and the occupancy count, generates storage strobes and
// addresses, and keeps registered full/empty/almost flags derived from the
// next-state pointers and count.
// Parameters:
//   AF_LEVEL : almost_full when count >= AF_LEVEL
//   AE_LEVEL : almost_empty when count <= AE_LEVEL
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (priority over flush)
//   bus  : fifo_ctrl_if.slave (requests in; strobes, flags, count out)
// ---------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    fifo_ctrl_if.slave bus
);

    ptr_t w_wptr;
    ptr_t w_rptr;
    ptr_t w_wptrNext;
    ptr_t w_rptrNext;
    cnt_t w_countNext;
    logic w_wrOk;
    logic w_rdOk;

    cnt_t r_count;
    logic r_full;
    logic r_empty;
    logic r_almostFull;
    logic r_almostEmpty;
    logic r_rdValid;
    logic r_overflow;
    logic r_underflow;

    // Acceptance looks only at the registered flags, so a read on an empty
    // FIFO is refused even if a write lands in the same cycle (no fall-through).
    assign w_wrOk = bus.wr_en & ~r_full  & ~bus.flush;
    assign w_rdOk = bus.rd_en & ~r_empty & ~bus.flush;

    fifo_ptr u_wptr (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_wrOk),
        .i_clr     (bus.flush),
        .o_ptr     (w_wptr),
        .o_ptrNext (w_wptrNext)
    );

    fifo_ptr u_rptr (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_rdOk),
        .i_clr     (bus.flush),
        .o_ptr     (w_rptr),
        .o_ptrNext (w_rptrNext)
    );

    // Occupancy next state; a simultaneous accepted read and write cancel out.
    always_comb begin
        w_countNext = r_count;
        if (bus.flush) begin
            w_countNext = '0;
        end else begin
            w_countNext = r_count + cnt_t'(w_wrOk) - cnt_t'(w_rdOk);
        end
    end

    // Status flags are decoded from next-state pointers/count and registered,
    // so they describe the FIFO as it stands after each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            r_count       <= w_countNext;
            r_full        <= ptr_full(w_wptrNext, w_rptrNext);
            r_empty       <= ptr_empty(w_wptrNext, w_rptrNext);
            r_almostFull  <= (w_countNext >= cnt_t'(AF_LEVEL));
            r_almostEmpty <= (w_countNext <= cnt_t'(AE_LEVEL));
        end
    end

    // Storage read data arrives one cycle after an accepted read; flush
    // already suppresses the read, so nothing is left in flight after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdOk;
        end
    end

    // Sticky error flags. A new error in the same cycle as clr_err wins so
    // the event is never lost; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.mem_we       = w_wrOk;
    assign bus.mem_waddr    = w_wptr[SIZE-1:0];
    assign bus.mem_re       = w_rdOk;
    assign bus.mem_raddr    = w_rptr[SIZE-1:0];
    assign bus.rd_valid     = r_rdValid;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almostFull;
    assign bus.almost_empty = r_almostEmpty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
// Directed, table-driven bench for fifo_ctrl (DEPTH 16, AF 14, AE 2).
// Each vector holds the requests for one cycle, the strobes/addresses
// expected during that cycle, and the registered state expected after the
// following rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

    typedef struct {
        string      tag;
        logic       rst;
        logic       wr;
        logic       rd;
        logic       fl;
        logic       ce;
        logic       expWe;
        logic       expRe;
        logic [3:0] expWaddr;
        logic [3:0] expRaddr;
        logic [4:0] expCount;
        logic       expFull;
        logic       expEmpty;
        logic       expAf;
        logic       expAe;
        logic       expValid;
        logic       expOvf;
        logic       expUdf;
    } vec_t;

    logic clk;
    logic rst;
    int   numChecks;
    int   numErrors;
    vec_t vecs[$];

    fifo_ctrl_if bus ();

    fifo_ctrl #(
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string tag, logic rs, logic wr, logic rd, logic fl, logic ce,
                                logic we, logic re, logic [3:0] wa, logic [3:0] ra,
                                logic [4:0] cnt, logic fu, logic em, logic af, logic ae,
                                logic va, logic ov, logic un);
        vec_t v;
        v.tag = tag; v.rst = rs; v.wr = wr; v.rd = rd; v.fl = fl; v.ce = ce;
        v.expWe = we; v.expRe = re; v.expWaddr = wa; v.expRaddr = ra;
        v.expCount = cnt; v.expFull = fu; v.expEmpty = em; v.expAf = af; v.expAe = ae;
        v.expValid = va; v.expOvf = ov; v.expUdf = un;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one vector at the falling edge, check the same-cycle strobes,
    // then check registered state just after the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        bus.wr_en   = v.wr;
        bus.rd_en   = v.rd;
        bus.flush   = v.fl;
        bus.clr_err = v.ce;
        #1;
        checkOutput({v.tag, ".mem_we"},    32'(bus.mem_we),    32'(v.expWe));
        checkOutput({v.tag, ".mem_re"},    32'(bus.mem_re),    32'(v.expRe));
        checkOutput({v.tag, ".mem_waddr"}, 32'(bus.mem_waddr), 32'(v.expWaddr));
        checkOutput({v.tag, ".mem_raddr"}, 32'(bus.mem_raddr), 32'(v.expRaddr));
        @(posedge clk);
        #1;
        checkOutput({v.tag, ".count"},        32'(bus.count),        32'(v.expCount));
        checkOutput({v.tag, ".full"},         32'(bus.full),         32'(v.expFull));
        checkOutput({v.tag, ".empty"},        32'(bus.empty),        32'(v.expEmpty));
        checkOutput({v.tag, ".almost_full"},  32'(bus.almost_full),  32'(v.expAf));
        checkOutput({v.tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(v.expAe));
        checkOutput({v.tag, ".rd_valid"},     32'(bus.rd_valid),     32'(v.expValid));
        checkOutput({v.tag, ".overflow"},     32'(bus.overflow),     32'(v.expOvf));
        checkOutput({v.tag, ".underflow"},    32'(bus.underflow),    32'(v.expUdf));
    endtask

    initial begin
        numChecks = 0;
        numErrors = 0;

        // Fill sequence: 16 writes, overflow handling, simultaneous reads/writes.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk($sformatf("fill%0d", i), 0, 1, 0, 0, 0, 1, 0, 4'(i), 4'd0,
                              5'(i + 1), i == 15, 0, (i + 1) >= 14, (i + 1) <= 2, 0, 0, 0));
        vecs.push_back(mk("wrFull",     0, 1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 5'd16, 1, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("ovfHold",    0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 5'd16, 1, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("ovfSetWins", 0, 1, 0, 0, 1, 0, 0, 4'd0, 4'd0, 5'd16, 1, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("ovfClr",     0, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 5'd16, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("bothFull",   0, 1, 1, 0, 0, 0, 1, 4'd0, 4'd0, 5'd15, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("both2",      0, 1, 1, 0, 0, 1, 1, 4'd0, 4'd1, 5'd15, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("both3",      0, 1, 1, 0, 0, 1, 1, 4'd1, 4'd2, 5'd15, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("clrAfter",   0, 0, 0, 0, 1, 0, 0, 4'd2, 4'd3, 5'd15, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("refill",     0, 1, 0, 0, 0, 1, 0, 4'd2, 4'd3, 5'd16, 1, 0, 1, 0, 0, 0, 0));

        // Drain all 16 entries, then one read on empty.
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk($sformatf("drain%0d", j), 0, 0, 1, 0, 0, 0, 1, 4'd3, 4'((3 + j) % 16),
                              5'(15 - j), 0, j == 15, (15 - j) >= 14, (15 - j) <= 2, 1, 0, 0));
        vecs.push_back(mk("rdEmpty", 0, 0, 1, 0, 0, 0, 0, 4'd3, 4'd3, 5'd0, 0, 1, 0, 1, 0, 0, 1));

        // 40 write/read pairs walking both pointers around the ring twice.
        for (int k = 0; k < 40; k++) begin
            vecs.push_back(mk($sformatf("pairW%0d", k), 0, 1, 0, 0, 0, 1, 0, 4'((3 + k) % 16),
                              4'((3 + k) % 16), 5'd1, 0, 0, 0, 1, 0, 0, 1));
            vecs.push_back(mk($sformatf("pairR%0d", k), 0, 0, 1, 0, 0, 0, 1, 4'((4 + k) % 16),
                              4'((3 + k) % 16), 5'd0, 0, 1, 0, 1, 1, 0, 1));
        end

        // Build count 7 with a read in flight, then flush.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("pre%0d", i), 0, 1, 0, 0, 0, 1, 0, 4'((11 + i) % 16), 4'd11,
                              5'(i + 1), 0, 0, 0, (i + 1) <= 2, 0, 0, 1));
        vecs.push_back(mk("preRd",    0, 0, 1, 0, 0, 0, 1, 4'd3, 4'd11, 5'd7, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("flushRd",  0, 0, 1, 1, 0, 0, 0, 4'd3, 4'd12, 5'd0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("flushWr",  0, 1, 0, 1, 0, 0, 0, 4'd0, 4'd0, 5'd0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("udfClr",   0, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 5'd0, 0, 1, 0, 1, 0, 0, 0));

        // Set underflow and build up nine writes ahead of a reset mid-write.
        vecs.push_back(mk("udfAgain", 0, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 5'd0, 0, 1, 0, 1, 0, 0, 1));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("w%0d", i), 0, 1, 0, 0, 0, 1, 0, 4'(i), 4'd0,
                              5'(i + 1), 0, 0, 0, (i + 1) <= 2, 0, 0, 1));
        vecs.push_back(mk("w8rd",     0, 1, 1, 0, 0, 1, 1, 4'd8, 4'd0, 5'd8, 0, 0, 0, 0, 1, 0, 1));

        // Power-on reset, then five idle cycles.
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.count", 32'(bus.count), 32'd0);
        checkOutput("reset.empty", 32'(bus.empty), 32'd1);
        checkOutput("reset.full",  32'(bus.full),  32'd0);
        for (int i = 0; i < 5; i++)
            applyStimulus(mk($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0,
                             5'd0, 0, 1, 0, 1, 0, 0, 0));

        foreach (vecs[n])
            applyStimulus(vecs[n]);

        // Reset arriving during the tenth write: the write strobe still
        // reflects acceptance, but everything returns to reset values.
        applyStimulus(mk("rstMidWr", 1, 1, 0, 0, 0, 1, 0, 4'd9, 4'd1, 5'd0, 0, 1, 0, 1, 0, 0, 0));
        applyStimulus(mk("postRst",  0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 5'd0, 0, 1, 0, 1, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
